// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC pulse-distance IR frame decoder on the 10 kHz tick.
// Decodes data frames and repeat frames from the active-low receiver output.
// Provides a valid/ack handshake with overrun flag, per-phase timeout/abort
// and a 2-flop input synchroniser.
// Optional build macro IR_NEC_CHECK_EN enables the address/command
// complement check at frame acceptance (NBITS must be 32 when defined).
module ir_nec_receiver #(
    parameter int unsigned NBITS       = 32,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LEAD_LO_MIN = 81,
    parameter int unsigned LEAD_LO_MAX = 109,
    parameter int unsigned LEAD_HI_MIN = 36,
    parameter int unsigned LEAD_HI_MAX = 49,
    parameter int unsigned RPT_HI_MIN  = 18,
    parameter int unsigned RPT_HI_MAX  = 27,
    parameter int unsigned BURST_MIN   = 3,
    parameter int unsigned BURST_MAX   = 9,
    parameter int unsigned BIT0_MIN    = 1,
    parameter int unsigned BIT0_MAX    = 9,
    parameter int unsigned BIT1_MIN    = 13,
    parameter int unsigned BIT1_MAX    = 18
) (
    input  logic             clk_10KHz,
    input  logic             stateReset,
    input  logic             ir_raw,
    input  logic             code_ack,
    output logic [NBITS-1:0] code,
    output logic             code_valid,
    output logic             rpt_pulse,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned BC_W = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LO,
        LEAD_HI,
        BIT_LO,
        BIT_HI,
        STOP,
        RPT_STOP
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] code_q, code_d;
    logic             code_valid_q, code_valid_d;
    logic             have_code_q, have_code_d;
    logic             rpt_pulse_q, rpt_pulse_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic             ir_s;
    logic             edge_seen;
    logic [31:0]      cnt_v;
    logic             abort;
    logic             accept;
    logic             chk_ok;

    function automatic logic in_rng(input logic [31:0] v, input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Next-state logic: synchroniser, level counter, frame FSM and handshake
    always_comb begin
        sync1_d      = ir_raw;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        have_code_d  = have_code_q;
        rpt_pulse_d  = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;
        abort        = 1'b0;
        accept       = 1'b0;

        ir_s      = sync2_q;
        edge_seen = ir_s ^ prev_q;
        cnt_v     = 32'(cnt_q);

        // On an edge cnt_q still holds the length of the level just ended
        if (edge_seen) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

`ifdef IR_NEC_CHECK_EN
        chk_ok = (shift_q[31:24] == ~shift_q[23:16]) &&
                 (shift_q[15:8]  == ~shift_q[7:0]);
`else
        chk_ok = 1'b1;
`endif

        // Each non-IDLE state classifies on its edge, else times out past its MAX
        case (state_q)
            IDLE: begin
                if (edge_seen && !ir_s) begin
                    state_d = LEAD_LO;
                end
            end
            LEAD_LO: begin
                if (edge_seen) begin
                    if (in_rng(cnt_v, LEAD_LO_MIN, LEAD_LO_MAX)) begin
                        state_d = LEAD_HI;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt_v > LEAD_LO_MAX) begin
                    abort = 1'b1;
                end
            end
            LEAD_HI: begin
                if (edge_seen) begin
                    if (in_rng(cnt_v, LEAD_HI_MIN, LEAD_HI_MAX)) begin
                        state_d   = BIT_LO;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else if (in_rng(cnt_v, RPT_HI_MIN, RPT_HI_MAX)) begin
                        state_d = RPT_STOP;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt_v > LEAD_HI_MAX) begin
                    abort = 1'b1;
                end
            end
            BIT_LO: begin
                if (edge_seen) begin
                    if (in_rng(cnt_v, BURST_MIN, BURST_MAX)) begin
                        state_d = BIT_HI;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt_v > BURST_MAX) begin
                    abort = 1'b1;
                end
            end
            BIT_HI: begin
                if (edge_seen) begin
                    if (in_rng(cnt_v, BIT0_MIN, BIT0_MAX) ||
                        in_rng(cnt_v, BIT1_MIN, BIT1_MAX)) begin
                        shift_d   = {shift_q[NBITS-2:0], in_rng(cnt_v, BIT1_MIN, BIT1_MAX)};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (32'(bit_cnt_q) == NBITS - 1) begin
                            state_d = STOP;
                        end else begin
                            state_d = BIT_LO;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt_v > BIT1_MAX) begin
                    abort = 1'b1;
                end
            end
            STOP: begin
                if (edge_seen) begin
                    if (in_rng(cnt_v, BURST_MIN, BURST_MAX) && chk_ok) begin
                        accept  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt_v > BURST_MAX) begin
                    abort = 1'b1;
                end
            end
            RPT_STOP: begin
                if (edge_seen) begin
                    if (in_rng(cnt_v, BURST_MIN, BURST_MAX) && have_code_q) begin
                        rpt_pulse_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (cnt_v > BURST_MAX) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            shift_d     = '0;
        end

        if (code_ack) begin
            overrun_d = 1'b0;
            if (code_valid_q) begin
                code_valid_d = 1'b0;
            end
        end

        // Acceptance overrides the ack-clear so an acked slot refills in the same cycle
        if (accept) begin
            if (!code_valid_q || code_ack) begin
                code_d       = shift_q;
                code_valid_d = 1'b1;
                have_code_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchroniser resets to the idle-high level
    always_ff @(posedge clk_10KHz or posedge stateReset) begin
        if (stateReset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            have_code_q  <= 1'b0;
            rpt_pulse_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            have_code_q  <= have_code_d;
            rpt_pulse_q  <= rpt_pulse_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign rpt_pulse  = rpt_pulse_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for ir_nec_receiver: nominal frames, repeat frames,
// overrun/ack handshake, leader/space/timeout aborts, optional integrity
// check (IR_NEC_CHECK_EN) and asynchronous mid-frame reset.
module tb_ir_nec_receiver;

    logic        clk_10KHz = 1'b0;
    logic        stateReset;
    logic        ir_raw;
    logic        code_ack;
    logic [31:0] code;
    logic        code_valid;
    logic        rpt_pulse;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;
    int rpt_cnt  = 0;
    int f0, r0;

    ir_nec_receiver #(.NBITS(32), .CNT_W(8)) dut (
        .clk_10KHz  (clk_10KHz),
        .stateReset (stateReset),
        .ir_raw     (ir_raw),
        .code_ack   (code_ack),
        .code       (code),
        .code_valid (code_valid),
        .rpt_pulse  (rpt_pulse),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk_10KHz = ~clk_10KHz;

    // Pulse counters; read at posedge so they see the settled previous-cycle value
    always @(posedge clk_10KHz) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (rpt_pulse === 1'b1) rpt_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        ir_raw = lvl;
        repeat (n) @(negedge clk_10KHz);
    endtask

    task automatic ack();
        code_ack = 1'b1;
        @(negedge clk_10KHz);
        code_ack = 1'b0;
        @(negedge clk_10KHz);
    endtask

    task automatic send_repeat();
        drive(1'b0, 90);
        drive(1'b1, 22);
        drive(1'b0, 6);
        drive(1'b1, 10);
    endtask

    // bad_idx >= 0 replaces that bit's space with bad_space and ends the frame there
    task automatic send_frame(input logic [31:0] c, input int bad_idx, input int bad_space,
                              input bit lat_chk);
        drive(1'b0, 90);
        drive(1'b1, 45);
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 6);
            if (k == bad_idx) begin
                drive(1'b1, bad_space);
                drive(1'b0, 6);
                drive(1'b1, 20);
                return;
            end
            drive(1'b1, c[31-k] ? 17 : 6);
        end
        drive(1'b0, 6);
        ir_raw = 1'b1;
        @(negedge clk_10KHz);
        @(negedge clk_10KHz);
        if (lat_chk) chk("valid_before_edge", 64'(code_valid), 64'd0);
        @(negedge clk_10KHz);
        if (lat_chk) chk("valid_latency", 64'(code_valid), 64'd1);
        repeat (5) @(negedge clk_10KHz);
    endtask

    initial begin
        stateReset = 1'b1;
        ir_raw     = 1'b1;
        code_ack   = 1'b0;
        repeat (3) @(negedge clk_10KHz);
        stateReset = 1'b0;
        repeat (5) @(negedge clk_10KHz);

        // Reset state
        chk("rst_code", 64'(code), 64'h0);
        chk("rst_valid", 64'(code_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ferr", 64'(frame_err), 64'd0);
        chk("rst_rpt", 64'(rpt_pulse), 64'd0);

        // Repeat frame with no stored code aborts
        f0 = ferr_cnt; r0 = rpt_cnt;
        send_repeat();
        chk("rpt_nocode_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("rpt_nocode_rpt", 64'(rpt_cnt - r0), 64'd0);
        chk("rpt_nocode_valid", 64'(code_valid), 64'd0);

        // Nominal frame with latency check, held until ack
        f0 = ferr_cnt;
        send_frame(32'h916E926D, -1, 0, 1'b1);
        chk("nom_code", 64'(code), 64'h916E926D);
        repeat (20) @(negedge clk_10KHz);
        chk("nom_valid_held", 64'(code_valid), 64'd1);
        chk("nom_ferr", 64'(ferr_cnt - f0), 64'd0);
        chk("nom_busy", 64'(busy), 64'd0);

        // Second frame without ack overruns and is dropped
        send_frame(32'h916E827D, -1, 0, 1'b0);
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_code", 64'(code), 64'h916E926D);
        chk("ovr_valid", 64'(code_valid), 64'd1);
        ack();
        chk("ack_valid", 64'(code_valid), 64'd0);
        chk("ack_overrun", 64'(overrun), 64'd0);
        chk("ack_code", 64'(code), 64'h916E926D);

        // Repeat frame after an accepted frame
        f0 = ferr_cnt; r0 = rpt_cnt;
        send_repeat();
        chk("rpt_pulse_cnt", 64'(rpt_cnt - r0), 64'd1);
        chk("rpt_ferr", 64'(ferr_cnt - f0), 64'd0);
        chk("rpt_code", 64'(code), 64'h916E926D);
        chk("rpt_valid", 64'(code_valid), 64'd0);

        // Short leader aborts, next frame accepted normally
        f0 = ferr_cnt;
        drive(1'b0, 60);
        drive(1'b1, 30);
        chk("shortlead_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("shortlead_valid", 64'(code_valid), 64'd0);
        send_frame(32'h916E02FD, -1, 0, 1'b0);
        chk("after_abort_code", 64'(code), 64'h916E02FD);
        chk("after_abort_valid", 64'(code_valid), 64'd1);
        ack();

        // Invalid 11-tick space at bit 5
        f0 = ferr_cnt;
        send_frame(32'h916E926D, 5, 11, 1'b0);
        chk("badspace_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("badspace_valid", 64'(code_valid), 64'd0);
        chk("badspace_busy", 64'(busy), 64'd0);

        // Leader low held too long: timeout without an edge
        f0 = ferr_cnt;
        drive(1'b0, 100);
        chk("tmo_busy_mid", 64'(busy), 64'd1);
        chk("tmo_ferr_mid", 64'(ferr_cnt - f0), 64'd0);
        drive(1'b0, 50);
        chk("tmo_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        drive(1'b1, 20);
        chk("tmo_ferr_after", 64'(ferr_cnt - f0), 64'd1);

        // Frame failing the complement check
        f0 = ferr_cnt;
        send_frame(32'h916E926C, -1, 0, 1'b0);
`ifdef IR_NEC_CHECK_EN
        chk("integ_ferr", 64'(ferr_cnt - f0), 64'd1);
        chk("integ_valid", 64'(code_valid), 64'd0);
        chk("integ_code", 64'(code), 64'h916E02FD);
`else
        chk("integ_ferr", 64'(ferr_cnt - f0), 64'd0);
        chk("integ_valid", 64'(code_valid), 64'd1);
        chk("integ_code", 64'(code), 64'h916E926C);
        ack();
`endif

        // Load a pending code, then reset mid-frame at bit 20
        send_frame(32'h916E926D, -1, 0, 1'b0);
        chk("pre_rst_valid", 64'(code_valid), 64'd1);
        f0 = ferr_cnt;
        drive(1'b0, 90);
        drive(1'b1, 45);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 6);
            drive(1'b1, 17);
        end
        drive(1'b0, 3);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 stateReset = 1'b1;
        #1;
        chk("midrst_code", 64'(code), 64'h0);
        chk("midrst_valid", 64'(code_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
        chk("midrst_ferr", 64'(frame_err), 64'd0);
        ir_raw = 1'b1;
        repeat (3) @(negedge clk_10KHz);
        stateReset = 1'b0;
        repeat (20) @(negedge clk_10KHz);
        chk("midrst_no_ferr", 64'(ferr_cnt - f0), 64'd0);
        chk("midrst_busy_after", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_nec_receiver.md
Name: ir_nec_receiver

Overview:
- Parametrised successor to the VCR IR front end: decodes NEC-style pulse-distance frames from the remote's active-low IR receiver output.
- Adds NEC repeat-frame detection, a valid/ack output handshake with overrun flagging, per-phase timeout/abort and an input synchroniser.
- Sits between the IR pin and the key-code-to-digit mapping logic and the seven-segment display path; runs on the 10 kHz system tick.

Parameters:
- NBITS, 32, payload bits per frame; shifted MSB-first, so the first received bit ends at code[NBITS-1].
- CNT_W, 8, level-duration counter width; counter saturates at 2^CNT_W-1.
- LEAD_LO_MIN / LEAD_LO_MAX, 81 / 109, accepted leader low length in ticks (nominal 90).
- LEAD_HI_MIN / LEAD_HI_MAX, 36 / 49, accepted data-frame leader high length (nominal 45).
- RPT_HI_MIN / RPT_HI_MAX, 18 / 27, accepted repeat-frame leader high length (nominal 22).
- BURST_MIN / BURST_MAX, 3 / 9, accepted mark (low burst) length (nominal 6).
- BIT0_MIN / BIT0_MAX, 1 / 9, high space length decoded as logic 0.
- BIT1_MIN / BIT1_MAX, 13 / 18, high space length decoded as logic 1.

Ports:
- clk_10KHz  in  1  10 kHz clock.
- stateReset  in  1  reset, asynchronous, active-high.
- ir_raw  in  1  raw IR receiver output; idle high, active low.
- code_ack  in  1  consumer acknowledge for code_valid.
- code  out  NBITS  last accepted payload.
- code_valid  out  1  new code available; held until acknowledged.
- rpt_pulse  out  1  one-cycle pulse on each accepted repeat frame.
- frame_err  out  1  one-cycle pulse on any frame abort.
- overrun  out  1  sticky; a frame completed while code_valid was pending.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Input synchronisation: ir_raw passes through a 2-flop synchroniser to give ir_s. All timing below refers to ir_s (2-cycle latency from ir_raw).
- Counter cnt:
  - Counts consecutive cycles at the current ir_s level.
  - On an edge cycle (ir_s differs from the previous sample), classification uses cnt = cycles spent at the previous level; cnt then restarts at 1.
- States: IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP, RPT_STOP.
  - IDLE: falling edge -> LEAD_LO.
  - LEAD_LO: rising edge with cnt in [LEAD_LO_MIN, LEAD_LO_MAX] -> LEAD_HI; otherwise abort.
  - LEAD_HI: falling edge:
    - cnt in the LEAD_HI range -> BIT_LO; bit count cleared.
    - cnt in the RPT_HI range -> RPT_STOP.
    - otherwise abort.
  - BIT_LO: rising edge with cnt in [BURST_MIN, BURST_MAX] -> BIT_HI; otherwise abort.
  - BIT_HI: falling edge:
    - cnt in the BIT0 range shifts in 0; cnt in the BIT1 range shifts in 1; bit count increments.
    - Next state is BIT_LO, or STOP if this was bit NBITS.
    - Any other cnt -> abort.
  - STOP: rising edge with a valid burst -> frame accepted, IDLE.
  - RPT_STOP: rising edge with a valid burst:
    - If have_code=1: rpt_pulse for 1 cycle; code and code_valid untouched.
    - If have_code=0: abort.
    - Either way -> IDLE.
- Timeout: in any non-IDLE state, cnt exceeding that state's MAX (BIT_HI uses BIT1_MAX) aborts immediately, without waiting for an edge.
- Abort: frame_err for 1 cycle, state IDLE, shift register discarded, code unchanged.
- Frame acceptance (the cycle after the STOP rising edge):
  - If code_valid=0, or code_ack=1 in that same cycle: code <= shift register, code_valid <= 1, have_code <= 1.
  - Otherwise the new frame is dropped and overrun <= 1.
- Handshake:
  - code_valid clears on the cycle after code_ack=1 is sampled with code_valid=1, unless a new frame is accepted in that cycle.
  - overrun clears on code_ack.
  - code_ack while code_valid=0 has no effect.
- Reset, asynchronous and usable mid-frame:
  - state IDLE, code=0, code_valid=0, rpt_pulse=0, frame_err=0, overrun=0, busy=0, have_code=0.
  - Synchroniser flops reset to 1 (idle level).
  - A frame in progress is lost and raises no frame_err.

Optional Feature:
- Macro: IR_NEC_CHECK_EN.
- Defined: at acceptance, require code[31:24] == ~code[23:16] and code[15:8] == ~code[7:0]. On mismatch, the frame aborts (frame_err pulse, no code update). NBITS must be 32 when defined.
- Undefined: no integrity check; any NBITS-bit frame is accepted.

Test Plan:
- Nominal frame 0x916E926D: lead 90L/45H; per bit 6L, then 17H for 1 or 6H for 0; stop 6L -> code=0x916E926D, code_valid=1 one cycle after the stop rising edge at ir_s, held until code_ack.
- Leader low of 60 ticks -> frame_err pulse, no code_valid; a following valid frame 0x916E02FD is accepted normally.
- Repeat 90L/22H/6L after an accepted frame -> one rpt_pulse, code unchanged. The same repeat issued directly after reset -> frame_err, no rpt_pulse.
- Frames 0x916E926D then 0x916E827D with no code_ack -> overrun=1, code stays 0x916E926D. Then code_ack -> code_valid=0, overrun=0.
- Bit space of 11 ticks at bit 5 -> frame_err, no code_valid. Separately, ir_s held low for 150 ticks -> timeout frame_err at cnt=110; busy=0 afterwards.
- With IR_NEC_CHECK_EN, frame 0x916E926C -> frame_err, no code_valid. Without the macro, the same frame -> code=0x916E926C, code_valid=1. Separately, stateReset asserted at bit 20 -> all outputs 0 immediately, no frame_err.
